// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: branch redirect/stall inputs, instruction-memory port and IF/ID outputs.
// MisalignErr exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              Stall;
    logic              Redirect;
    logic [ADDR_W-1:0] RedirectPc;
    logic [ADDR_W-1:0] ImemAddr;
    logic              ImemReq;
    logic              ImemReady;
    logic [31:0]       ImemData;
    logic [31:0]       Instr;
    logic [ADDR_W-1:0] PcP4;
    logic              InstrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic              MisalignErr;
`endif

    modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
        output MisalignErr,
`endif
        input  Stall, Redirect, RedirectPc, ImemReady, ImemData,
        output ImemAddr, ImemReq, Instr, PcP4, InstrValid
    );

    modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
        input  MisalignErr,
`endif
        output Stall, Redirect, RedirectPc, ImemReady, ImemData,
        input  ImemAddr, ImemReq, Instr, PcP4, InstrValid
    );
endinterface

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; one-cycle latency, hold is the stall path.
module if_id_reg #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pcp4_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pcp4_o,
    output logic              valid_o
);
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pcp4_q;
    logic              valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // A bubble keeps the last PcP4; only the instruction becomes a NOP.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pcp4_q  <= pcp4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pcp4_o  = pcp4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch FSM with a one-entry skid for words returned under Stall; fetch-to-IF/ID is 1 cycle.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a sticky MisalignErr that halts fetching.
module pc_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(fetch_pkg::RESET_PC_DEF),
    parameter logic [31:0]       NOP_INSTR = fetch_pkg::NOP_INSTR_DEF
) (
    input logic              Clk,
    input logic              Rst,
    pc_fetch_unit_if.master  bus
);
    import fetch_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
    logic [ADDR_W-1:0] skid_pcp4_q, skid_pcp4_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic              trap_q, redir_bad;
    logic              ifid_load, ifid_flush;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pcp4;

    assign pc_plus4     = pc_q + ADDR_W'(PC_INC);
    assign bus.ImemAddr = pc_q;
    assign bus.ImemReq  = Rst && (state_q == FETCH) && !trap_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_bad = bus.Redirect && (bus.RedirectPc[1:0] != 2'b00);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            trap_q <= 1'b0;
        end else if (redir_bad) begin
            trap_q <= 1'b1;
        end
    end

    assign bus.MisalignErr = trap_q;
`else
    assign redir_bad = 1'b0;
    assign trap_q    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pcp4_d  = skid_pcp4_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr   = bus.ImemData;
        ifid_pcp4    = pc_plus4;

        if (bus.Redirect) begin
            // Any word arriving this cycle belongs to the wrong path and is dropped with the skid.
            ifid_flush = 1'b1;
            state_d    = FETCH;
            if (!redir_bad) begin
                pc_d = {bus.RedirectPc[ADDR_W-1:2], 2'b00};
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (trap_q) begin
                        state_d = FETCH;
                    end else if (bus.ImemReady) begin
                        if (bus.Stall) begin
                            skid_instr_d = bus.ImemData;
                            skid_pcp4_d  = pc_plus4;
                            state_d      = HELD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                        end
                    end else if (!bus.Stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HELD: begin
                    if (!bus.Stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid_instr_q;
                        ifid_pcp4  = skid_pcp4_q;
                        pc_d       = skid_pcp4_q;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pcp4_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp4_q  <= skid_pcp4_d;
        end
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i   (Clk),
        .rst_ni  (Rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .instr_i (ifid_instr),
        .pcp4_i  (ifid_pcp4),
        .instr_o (bus.Instr),
        .pcp4_o  (bus.PcP4),
        .valid_o (bus.InstrValid)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle reference model plus hand-computed checkpoints.
module tb_pc_fetch_unit;
    logic Clk = 1'b0;
    logic Rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    pc_fetch_unit_if #(.ADDR_W(32)) bus ();

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: what IF/ID and the PC must be, from the fetch rules.
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid;
    logic        m_trap;
    logic [31:0] m_skid[$];

    always @(posedge Clk) begin
        if (!Rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
            m_trap = 1'b0; m_skid.delete();
        end else if (bus.Redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.RedirectPc[1:0] != 2'b00) m_trap = 1'b1;
            else m_pc = bus.RedirectPc & 32'hFFFF_FFFC;
`else
            m_pc = bus.RedirectPc & 32'hFFFF_FFFC;
`endif
            m_valid = 1'b0; m_instr = 32'h0; m_skid.delete();
        end else if (m_skid.size() > 0) begin
            if (!bus.Stall) begin
                m_instr = m_skid.pop_front(); m_pcp4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (!m_trap) begin
            if (bus.ImemReady) begin
                if (bus.Stall) m_skid.push_back(bus.ImemData);
                else begin
                    m_instr = bus.ImemData; m_pcp4 = m_pc + 32'd4;
                    m_valid = 1'b1; m_pc = m_pc + 32'd4;
                end
            end else if (!bus.Stall) begin
                m_valid = 1'b0; m_instr = 32'h0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("m_addr",  bus.ImemAddr, m_pc);
            chk("m_req",   {31'b0, bus.ImemReq}, {31'b0, Rst && m_skid.size() == 0 && !m_trap});
            chk("m_instr", bus.Instr, m_instr);
            chk("m_pcp4",  bus.PcP4, m_pcp4);
            chk("m_valid", {31'b0, bus.InstrValid}, {31'b0, m_valid});
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("m_mis",   {31'b0, bus.MisalignErr}, {31'b0, m_trap});
`endif
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectPc = 32'h0;
        bus.ImemReady = 1'b0; bus.ImemData = 32'h0;
        chk_en = 1'b1;
        step(); step();
        chk("rst_valid", {31'b0, bus.InstrValid}, 32'h0);
        chk("rst_instr", bus.Instr, 32'h0);
        chk("rst_pcp4",  bus.PcP4, 32'h0);
        chk("rst_req",   {31'b0, bus.ImemReq}, 32'h0);
        chk("rst_addr",  bus.ImemAddr, 32'h0);

        Rst = 1'b1; bus.ImemReady = 1'b1; bus.ImemData = 32'h2001_0005; #1;
        chk("first_req",  {31'b0, bus.ImemReq}, 32'h1);
        chk("first_addr", bus.ImemAddr, 32'h0);
        step();
        chk("f1_instr", bus.Instr, 32'h2001_0005);
        chk("f1_pcp4",  bus.PcP4, 32'h4);
        chk("f1_valid", {31'b0, bus.InstrValid}, 32'h1);
        chk("f1_addr",  bus.ImemAddr, 32'h4);

        bus.ImemData = 32'h1111_0002; step();
        chk("f2_addr", bus.ImemAddr, 32'h8);

        // Stall while the word at PC=8 is returned: it must wait in the skid.
        bus.ImemData = 32'hAAAA_0001; bus.Stall = 1'b1; step();
        chk("held_req", {31'b0, bus.ImemReq}, 32'h0);
        bus.ImemData = 32'hDEAD_BEEF; step(); step();
        chk("held_instr", bus.Instr, 32'h1111_0002);
        chk("held_pcp4",  bus.PcP4, 32'h8);
        chk("held_addr",  bus.ImemAddr, 32'h8);
        bus.Stall = 1'b0; bus.ImemData = 32'h3333_0003; step();
        chk("rel_instr", bus.Instr, 32'hAAAA_0001);
        chk("rel_pcp4",  bus.PcP4, 32'hC);
        chk("rel_addr",  bus.ImemAddr, 32'hC);

        bus.ImemData = 32'h4444_0004; step();
        chk("f16_addr", bus.ImemAddr, 32'h10);
        bus.ImemReady = 1'b0; step();
        chk("bub1_valid", {31'b0, bus.InstrValid}, 32'h0);
        chk("bub1_addr",  bus.ImemAddr, 32'h10);
        step();
        chk("bub2_valid", {31'b0, bus.InstrValid}, 32'h0);
        chk("bub2_addr",  bus.ImemAddr, 32'h10);
        chk("bub2_pcp4",  bus.PcP4, 32'h10);

        // Redirect beats Stall while HELD; the skidded word must vanish.
        bus.ImemReady = 1'b1; bus.ImemData = 32'h5555_0005; bus.Stall = 1'b1; step();
        bus.Redirect = 1'b1; bus.RedirectPc = 32'h40; step();
        chk("redir_addr",  bus.ImemAddr, 32'h40);
        chk("redir_valid", {31'b0, bus.InstrValid}, 32'h0);
        chk("redir_instr", bus.Instr, 32'h0);
        bus.Redirect = 1'b0; bus.Stall = 1'b0; bus.ImemData = 32'h6666_0006; step();
        chk("post_redir_instr", bus.Instr, 32'h6666_0006);
        chk("post_redir_pcp4",  bus.PcP4, 32'h44);

`ifndef FETCH_MISALIGN_TRAP_EN
        bus.Redirect = 1'b1; bus.RedirectPc = 32'h4E; bus.ImemData = 32'h7777_0007; step();
        chk("align_addr",  bus.ImemAddr, 32'h4C);
        chk("align_valid", {31'b0, bus.InstrValid}, 32'h0);
`endif

        bus.Redirect = 1'b1; bus.RedirectPc = 32'hFFFF_FFFC; step();
        bus.Redirect = 1'b0; bus.ImemData = 32'h8888_0008;
        chk("top_addr", bus.ImemAddr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pcp4",  bus.PcP4, 32'h0);
        chk("wrap_addr",  bus.ImemAddr, 32'h0);
        chk("wrap_instr", bus.Instr, 32'h8888_0008);

        // Reset while HELD abandons the skidded word.
        bus.ImemData = 32'h1234_0000; step();
        bus.ImemData = 32'h9999_0009; bus.Stall = 1'b1; step();
        Rst = 1'b0; step();
        chk("mrst_addr",  bus.ImemAddr, 32'h0);
        chk("mrst_pcp4",  bus.PcP4, 32'h0);
        chk("mrst_valid", {31'b0, bus.InstrValid}, 32'h0);
        Rst = 1'b1; bus.Stall = 1'b0; bus.ImemData = 32'hAAAA_000A; step();
        chk("mrst_instr", bus.Instr, 32'hAAAA_000A);
        chk("mrst_pcp4b", bus.PcP4, 32'h4);

        // Mixed stall/ready/redirect pattern, checked by the reference model.
        for (int i = 0; i < 48; i++) begin
            bus.Stall      = (i % 5 == 2) || (i % 7 == 3);
            bus.ImemReady  = (i % 4 != 1);
            bus.Redirect   = (i == 20) || (i == 37);
            bus.RedirectPc = 32'h100 + 32'(i * 8);
            bus.ImemData   = 32'hC000_0000 + 32'(i);
            step();
        end
        bus.Redirect = 1'b0; bus.Stall = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
        begin
            logic [31:0] pc_before;
            step();
            pc_before = bus.ImemAddr;
            bus.Redirect = 1'b1; bus.RedirectPc = 32'h42; step();
            bus.Redirect = 1'b0;
            chk("trap_err",   {31'b0, bus.MisalignErr}, 32'h1);
            chk("trap_addr",  bus.ImemAddr, pc_before);
            chk("trap_req",   {31'b0, bus.ImemReq}, 32'h0);
            chk("trap_valid", {31'b0, bus.InstrValid}, 32'h0);
            step(); step();
            chk("trap_sticky", {31'b0, bus.MisalignErr}, 32'h1);
            Rst = 1'b0; step();
            chk("trap_clr", {31'b0, bus.MisalignErr}, 32'h0);
            Rst = 1'b1; step();
        end
`endif

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
